// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: owns the PC, keeps DEPTH imem requests in flight and splits fields at the FIFO head.
// Define FETCH_PERF_CNT_EN to add saturating perf_fetched/perf_flushed counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] instruction,
    output logic [31:0] ins_pc,
    output logic [5:0]  opCode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm16
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic          run;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [CW-1:0] out_next;
    logic [CW:0]   inflight;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] pq_wr;
    logic [AW-1:0] pq_rd;

    logic [31:0] fifo_data [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] pc_queue  [DEPTH];

    logic accept;
    logic rsp;
    logic keep;
    logic pop;

    // Slots are reserved at issue, so a kept response always finds room.
    assign inflight       = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = run && !Reset && !redirect
                          && (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;

    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp      = imem_rsp_valid;
    assign keep     = rsp && (drop == '0) && !redirect;
    assign pop      = ins_valid && ins_ready;
    assign out_next = outstanding + CW'(accept) - CW'(rsp);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc          <= RESET_PC;
            run         <= 1'b0;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= out_next;
            if (accept) begin
                pq_wr <= pq_wr + AW'(1);
                pc    <= pc + 32'd4;
            end
            if (rsp) begin
                pq_rd <= pq_rd + AW'(1);
            end
            if (redirect) begin
                // Everything still in flight belongs to the old path.
                pc     <= redirect_pc & ~32'd3;
                drop   <= out_next;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (rsp && drop != '0) begin
                    drop <= drop - CW'(1);
                end
                if (keep) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            pc_queue[pq_wr] <= pc;
        end
        if (!Reset && keep) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= pc_queue[pq_rd];
        end
    end

    assign ins_valid   = count != '0;
    assign instruction = ins_valid ? fifo_data[rd_ptr] : 32'd0;
    assign ins_pc      = ins_valid ? fifo_pc[rd_ptr] : 32'd0;
    assign opCode      = instruction[31:26];
    assign rs          = instruction[25:21];
    assign rt          = instruction[20:16];
    assign rd          = instruction[15:11];
    assign funct       = instruction[5:0];
    assign imm16       = instruction[15:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flush_n;
    logic [32:0] fetch_sum;
    logic [32:0] flush_sum;

    always_comb begin
        flush_n = 32'd0;
        if (redirect) begin
            flush_n = 32'(count) - 32'(pop) + 32'(rsp);
        end else if (rsp && drop != '0) begin
            flush_n = 32'd1;
        end
    end

    assign fetch_sum = {1'b0, perf_fetched} + {32'd0, pop};
    assign flush_sum = {1'b0, perf_flushed} + {1'b0, flush_n};

    always_ff @(posedge CLK) begin
        if (Reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= fetch_sum[32] ? 32'hFFFF_FFFF : fetch_sum[31:0];
            perf_flushed <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
        end
    end
`endif

    rsp_needs_request: assert property (
        @(posedge CLK) disable iff (Reset)
        imem_rsp_valid |-> (outstanding != '0)
    );

endmodule
